// File: rtl/keypad_conditioner.sv
// Keypad input conditioner: synchronises, debounces and validates the ten raw
// oven key lines, producing a clean zero-or-one-hot keypad bus with event pulses.
module keypad_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_WIDTH       = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [9:0] raw_keys,
   input  logic       lock,
   output logic [9:0] keypad,
   output logic       key_valid,
   output logic       multi_key
);

   typedef enum logic [1:0] {
      IDLE,
      DEBOUNCE,
      PRESSED,
      RELEASE_WAIT
   } state_t;

   localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);

   state_t               r_state;
   logic [9:0]           r_sync1;
   logic [9:0]           r_sync2;
   logic [CNT_WIDTH-1:0] r_count;
   logic [9:0]           r_candidate;
   logic [9:0]           r_keypad;
   logic                 r_keyValid;
   logic                 r_multiKey;
   logic                 r_multiSeen;

   logic [9:0]           w_sync;
   logic                 w_anyKey;
   logic                 w_oneHot;
   logic                 w_multi;

   // Clearing the lowest set bit leaves zero only for a single-bit pattern.
   assign w_sync   = r_sync2;
   assign w_anyKey = (w_sync != 10'd0);
   assign w_oneHot = w_anyKey && ((w_sync & (w_sync - 10'd1)) == 10'd0);
   assign w_multi  = w_anyKey && !w_oneHot;

   assign keypad    = r_keypad;
   assign key_valid = r_keyValid;
   assign multi_key = r_multiKey;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= IDLE;
         r_sync1     <= '0;
         r_sync2     <= '0;
         r_count     <= '0;
         r_candidate <= '0;
         r_keypad    <= '0;
         r_keyValid  <= 1'b0;
         r_multiKey  <= 1'b0;
         r_multiSeen <= 1'b0;
      end else begin
         r_sync1    <= raw_keys;
         r_sync2    <= r_sync1;
         r_keyValid <= 1'b0;
         r_multiKey <= 1'b0;

         // The multi-key report re-arms only once every line has gone quiet.
         if (!w_anyKey) begin
            r_multiSeen <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               r_keypad <= '0;
               if (!lock) begin
                  if (w_oneHot) begin
                     r_candidate <= w_sync;
                     r_count     <= '0;
                     r_state     <= DEBOUNCE;
                  end else if (w_multi && !r_multiSeen) begin
                     r_multiKey  <= 1'b1;
                     r_multiSeen <= 1'b1;
                  end
               end
            end

            DEBOUNCE: begin
               if ((w_sync != r_candidate) || lock) begin
                  r_count <= '0;
                  r_state <= IDLE;
               end else if (r_count == LAST_COUNT) begin
                  r_keypad   <= r_candidate;
                  r_keyValid <= 1'b1;
                  r_state    <= PRESSED;
               end else begin
                  r_count <= r_count + ONE;
               end
            end

            // Lock is deliberately ignored from here on so a held key is never cut short.
            PRESSED: begin
               if (w_sync != r_candidate) begin
                  r_count <= '0;
                  r_state <= RELEASE_WAIT;
               end
            end

            RELEASE_WAIT: begin
               if (w_anyKey) begin
                  r_count <= '0;
               end else if (r_count == LAST_COUNT) begin
                  r_keypad    <= '0;
                  r_candidate <= '0;
                  r_count     <= '0;
                  r_state     <= IDLE;
               end else begin
                  r_count <= r_count + ONE;
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
